// File: rtl/sar_result_reader_pkg.sv
// Shared widths, FSM state encodings and a saturating-increment helper for the
// SAR result reader and its frame serializer.
package sar_pkg;
  localparam int N_BITS = 10;
  localparam int OVR_W  = 8;

  typedef enum logic [1:0] {L_IDLE, L_START, L_BUSY, L_GAP} launch_state_e;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_END} ser_state_e;

  function automatic logic [OVR_W-1:0] sat_inc(input logic [OVR_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/sar_result_reader_if.sv
// Bundle of the SAR-side handshake, SPI-style frame pins and status outputs.
interface sar_result_reader_if #(parameter int N_BITS = 10);
  logic                       enable;
  logic                       eoc;
  logic [N_BITS-1:0]          sar;
  logic                       cnvst;
  logic                       busy;
  logic                       cs_n;
  logic                       sclk_out;
  logic                       sdo;
  logic [N_BITS-1:0]          last_code;
  logic [sar_pkg::OVR_W-1:0]  overrun_cnt;
  logic                       timeout_flag;

  modport master (
    input  enable, eoc, sar,
    output cnvst, busy, cs_n, sclk_out, sdo, last_code, overrun_cnt, timeout_flag
  );
  modport slave (
    output enable, eoc, sar,
    input  cnvst, busy, cs_n, sclk_out, sdo, last_code, overrun_cnt, timeout_flag
  );
endinterface

// File: rtl/sar_frame_serializer.sv
// Shifts one captured code out MSB first as a cs_n/sclk/sdo frame, followed by
// a fixed deselect gap; accepts a new word only while idle.
module sar_frame_serializer #(
  parameter int N_BITS   = 10,
  parameter int SCLK_DIV = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [N_BITS-1:0] data_i,
  output logic              ready_o,
  output logic              cs_n_o,
  output logic              sclk_o,
  output logic              sdo_o
);
  import sar_pkg::*;

  localparam int PER   = 2 * SCLK_DIV;
  localparam int PER_W = $clog2(PER + 1);
  localparam int BIT_W = $clog2(N_BITS + 1);

  ser_state_e        state_q;
  logic [N_BITS-1:0] shreg_q;
  logic [PER_W-1:0]  per_q;
  logic [BIT_W-1:0]  bit_q;
  logic              cs_n_q, sclk_q, sdo_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      sdo_q   <= 1'b0;
      per_q   <= '0;
      bit_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (load_i) begin
          shreg_q <= data_i;
          sdo_q   <= data_i[N_BITS-1];
          cs_n_q  <= 1'b0;
          state_q <= S_LOAD;
        end
        S_LOAD: begin
          per_q   <= '0;
          bit_q   <= '0;
          state_q <= S_SHIFT;
        end
        S_SHIFT: begin
          // Outputs are registered, so each decision sets next cycle's pin values.
          if (per_q == PER_W'(PER - 1)) begin
            per_q  <= '0;
            sclk_q <= 1'b0;
            if (bit_q == BIT_W'(N_BITS - 1)) begin
              cs_n_q  <= 1'b1;
              sdo_q   <= 1'b0;
              state_q <= S_END;
            end else begin
              bit_q   <= bit_q + 1'b1;
              shreg_q <= shreg_q << 1;
              sdo_q   <= shreg_q[N_BITS-2];
            end
          end else begin
            per_q  <= per_q + 1'b1;
            sclk_q <= (per_q >= PER_W'(SCLK_DIV - 1));
          end
        end
        S_END: begin
          if (per_q == PER_W'(PER - 1)) state_q <= S_IDLE;
          else                          per_q   <= per_q + 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ready_o = (state_q == S_IDLE);
  assign cs_n_o  = cs_n_q;
  assign sclk_o  = sclk_q;
  assign sdo_o   = sdo_q;
endmodule

// File: rtl/sar_result_reader.sv
// Paces SAR conversions, captures results into a one-entry hold buffer and
// hands them to the frame serializer; tracks overruns and hung conversions.
module sar_result_reader #(
  parameter int N_BITS      = sar_pkg::N_BITS,
  parameter int CONV_PERIOD = 64,
  parameter int SCLK_DIV    = 2,
  parameter int TIMEOUT     = 255
) (
  input logic               clk,
  input logic               rst,
  sar_result_reader_if.master bus
);
  import sar_pkg::*;

  localparam int PC_W = 10;
  localparam int BC_W = $clog2(TIMEOUT + 1);

  launch_state_e     l_state_q;
  logic [PC_W-1:0]   period_q;
  logic [BC_W-1:0]   busy_cnt_q;
  logic              cnvst_q, busy_q, tflag_q;
  logic [N_BITS-1:0] hold_q, last_code_q;
  logic              hold_vld_q, hold_vld_d;
  logic [OVR_W-1:0]  ovr_q, ovr_d;
  logic              capture, load, ser_ready;
  logic              cs_n_w, sclk_w, sdo_w;

  assign capture = bus.eoc && (l_state_q == L_BUSY);
  assign load    = hold_vld_q && ser_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      l_state_q  <= L_IDLE;
      cnvst_q    <= 1'b0;
      busy_q     <= 1'b0;
      tflag_q    <= 1'b0;
      period_q   <= '0;
      busy_cnt_q <= '0;
    end else begin
      if (period_q != '1) period_q <= period_q + 1'b1;
      case (l_state_q)
        L_IDLE: if (bus.enable) begin
          cnvst_q   <= 1'b1;
          period_q  <= '0;
          l_state_q <= L_START;
        end
        L_START: begin
          cnvst_q    <= 1'b0;
          busy_q     <= 1'b1;
          busy_cnt_q <= '0;
          l_state_q  <= L_BUSY;
        end
        L_BUSY: begin
          busy_cnt_q <= busy_cnt_q + 1'b1;
          if (bus.eoc) begin
            busy_q    <= 1'b0;
            l_state_q <= L_GAP;
          end else if (busy_cnt_q == BC_W'(TIMEOUT - 1)) begin
            busy_q    <= 1'b0;
            tflag_q   <= 1'b1;
            l_state_q <= L_GAP;
          end
        end
        L_GAP: if (period_q >= PC_W'(CONV_PERIOD - 1)) begin
          // A long conversion may already be past the period point: start at once.
          if (bus.enable) begin
            cnvst_q   <= 1'b1;
            period_q  <= '0;
            l_state_q <= L_START;
          end else begin
            l_state_q <= L_IDLE;
          end
        end
        default: l_state_q <= L_IDLE;
      endcase
    end
  end

  // A capture coinciding with a hand-off refills the freed slot, so it is not a drop.
  always_comb begin
    hold_vld_d = hold_vld_q;
    ovr_d      = ovr_q;
    if (capture) begin
      hold_vld_d = 1'b1;
      if (hold_vld_q && !load) ovr_d = sat_inc(ovr_q);
    end else if (load) begin
      hold_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_vld_q  <= 1'b0;
      ovr_q       <= '0;
      last_code_q <= '0;
    end else begin
      hold_vld_q <= hold_vld_d;
      ovr_q      <= ovr_d;
      if (capture) last_code_q <= bus.sar;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) hold_q <= bus.sar;
  end

  sar_frame_serializer #(.N_BITS(N_BITS), .SCLK_DIV(SCLK_DIV)) u_ser (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .data_i  (hold_q),
    .ready_o (ser_ready),
    .cs_n_o  (cs_n_w),
    .sclk_o  (sclk_w),
    .sdo_o   (sdo_w)
  );

  assign bus.cnvst        = cnvst_q;
  assign bus.busy         = busy_q;
  assign bus.cs_n         = cs_n_w;
  assign bus.sclk_out     = sclk_w;
  assign bus.sdo          = sdo_w;
  assign bus.last_code    = last_code_q;
  assign bus.overrun_cnt  = ovr_q;
  assign bus.timeout_flag = tflag_q;
endmodule

// File: tb/tb_sar_result_reader.sv
// Directed bench: a default-rate instance and a fast-rate/slow-clock instance,
// each driven by a small SAR responder and observed by a frame decoder.
module tb_sar_result_reader;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sar_result_reader_if #(.N_BITS(10)) if0 ();
  sar_result_reader_if #(.N_BITS(10)) if1 ();

  sar_result_reader #(.N_BITS(10), .CONV_PERIOD(64), .SCLK_DIV(2), .TIMEOUT(255)) u0 (
    .clk(clk), .rst(rst), .bus(if0));
  sar_result_reader #(.N_BITS(10), .CONV_PERIOD(20), .SCLK_DIV(4), .TIMEOUT(255)) u1 (
    .clk(clk), .rst(rst), .bus(if1));

  logic       drv_en[2], drv_eoc[2];
  logic [9:0] drv_sar[2];
  logic       mon_cnvst[2], mon_cs_n[2], mon_sclk[2], mon_sdo[2];

  assign if0.enable = drv_en[0];  assign if1.enable = drv_en[1];
  assign if0.eoc    = drv_eoc[0]; assign if1.eoc    = drv_eoc[1];
  assign if0.sar    = drv_sar[0]; assign if1.sar    = drv_sar[1];
  assign mon_cnvst[0] = if0.cnvst;    assign mon_cnvst[1] = if1.cnvst;
  assign mon_cs_n[0]  = if0.cs_n;     assign mon_cs_n[1]  = if1.cs_n;
  assign mon_sclk[0]  = if0.sclk_out; assign mon_sclk[1]  = if1.sclk_out;
  assign mon_sdo[0]   = if0.sdo;      assign mon_sdo[1]   = if1.sdo;

  // SAR responder state
  logic [9:0] codes[2][16];
  int         lats[2][16];
  int         cidx[2], arm[2], eoc_cyc[2];
  logic       sar_on[2];

  // frame decoder / cnvst log
  int         cnv_n[2], frm_n[2];
  int         cnv_cyc[2][64];
  logic [9:0] frm_code[2][16];
  int         frm_len[2][16], frm_nb[2][16], frm_start[2][16];
  logic       infr[2], psclk[2];
  logic [9:0] fbits[2];
  int         flen[2], fnb[2], fstart[2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      drv_eoc[i] = 1'b0; drv_sar[i] = '0; arm[i] = 0; cidx[i] = 0; eoc_cyc[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        drv_eoc[i] = 1'b0;
        if (arm[i] > 0) begin
          arm[i]--;
          if (arm[i] == 0) begin
            drv_eoc[i] = 1'b1;
            drv_sar[i] = codes[i][cidx[i] % 16];
            eoc_cyc[i] = cyc;
            cidx[i]++;
          end
        end else if (mon_cnvst[i] && sar_on[i]) begin
          arm[i] = lats[i][cidx[i] % 16];
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      cnv_n[i] = 0; frm_n[i] = 0; infr[i] = 1'b0; psclk[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (mon_cnvst[i] && cnv_n[i] < 64) begin
          cnv_cyc[i][cnv_n[i]] = cyc;
          cnv_n[i]++;
        end
        if (!mon_cs_n[i]) begin
          if (!infr[i]) begin
            infr[i] = 1'b1; flen[i] = 0; fnb[i] = 0; fbits[i] = '0; fstart[i] = cyc;
          end
          flen[i]++;
          if (mon_sclk[i] && !psclk[i]) begin
            fbits[i] = {fbits[i][8:0], mon_sdo[i]};
            fnb[i]++;
          end
        end else if (infr[i]) begin
          infr[i] = 1'b0;
          if (frm_n[i] < 16) begin
            frm_code[i][frm_n[i]]  = fbits[i];
            frm_len[i][frm_n[i]]   = flen[i];
            frm_nb[i][frm_n[i]]    = fnb[i];
            frm_start[i][frm_n[i]] = fstart[i];
            frm_n[i]++;
          end
        end
        psclk[i] = mon_sclk[i];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cnv_n[i] = 0; frm_n[i] = 0; cidx[i] = 0; arm[i] = 0;
    end
  endtask

  task automatic wait_cnv(input int i, input int n, input int budget);
    int k = 0;
    while (cnv_n[i] < n && k < budget) begin tick(); k++; end
    if (cnv_n[i] < n) chk("wait_cnvst", 32'(cnv_n[i]), 32'(n));
  endtask

  task automatic wait_frm(input int i, input int n, input int budget);
    int k = 0;
    while (frm_n[i] < n && k < budget) begin tick(); k++; end
    if (frm_n[i] < n) chk("wait_frame", 32'(frm_n[i]), 32'(n));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, c0, f0;
    rst = 1'b1;
    drv_en[0] = 1'b0; drv_en[1] = 1'b0;
    sar_on[0] = 1'b1; sar_on[1] = 1'b1;
    repeat (3) tick();
    chk("rst_cnvst", 32'(if0.cnvst), 32'd0);
    chk("rst_busy", 32'(if0.busy), 32'd0);
    chk("rst_cs_n", 32'(if0.cs_n), 32'd1);
    chk("rst_sclk", 32'(if0.sclk_out), 32'd0);
    chk("rst_sdo", 32'(if0.sdo), 32'd0);
    chk("rst_last_code", 32'(if0.last_code), 32'd0);
    chk("rst_overrun", 32'(if0.overrun_cnt), 32'd0);
    chk("rst_timeout", 32'(if0.timeout_flag), 32'd0);

    // single code
    do_reset();
    codes[0][0] = 10'h2A5; lats[0][0] = 12;
    drv_en[0] = 1'b1;
    wait_cnv(0, 1, 10);
    drv_en[0] = 1'b0;
    tick();
    chk("t1_cnvst_one_cycle", 32'(if0.cnvst), 32'd0);
    chk("t1_busy", 32'(if0.busy), 32'd1);
    k = 0;
    while (!if0.eoc && k < 300) begin tick(); k++; end
    chk("t1_eoc_seen", 32'(if0.eoc), 32'd1);
    chk("t1_last_code_before", 32'(if0.last_code), 32'd0);
    tick();
    chk("t1_last_code_after", 32'(if0.last_code), 32'h2A5);
    chk("t1_cs_n_n1", 32'(if0.cs_n), 32'd1);
    tick();
    chk("t1_cs_n_n2", 32'(if0.cs_n), 32'd0);
    chk("t1_sdo_msb", 32'(if0.sdo), 32'd1);
    chk("t1_sclk_low", 32'(if0.sclk_out), 32'd0);
    wait_frm(0, 1, 100);
    chk("t1_frame_code", 32'(frm_code[0][0]), 32'h2A5);
    chk("t1_frame_len", 32'(frm_len[0][0]), 32'd41);
    chk("t1_frame_bits", 32'(frm_nb[0][0]), 32'd10);
    repeat (80) tick();
    chk("t1_cnvst_count", 32'(cnv_n[0]), 32'd1);
    chk("t1_overrun", 32'(if0.overrun_cnt), 32'd0);

    // back-to-back at the default rate
    do_reset();
    codes[0][0] = 10'h000; codes[0][1] = 10'h3FF; codes[0][2] = 10'h155; codes[0][3] = 10'h2AA;
    for (int j = 0; j < 4; j++) lats[0][j] = 12;
    drv_en[0] = 1'b1;
    wait_cnv(0, 4, 400);
    drv_en[0] = 1'b0;
    wait_frm(0, 4, 300);
    repeat (80) tick();
    chk("t2_frames", 32'(frm_n[0]), 32'd4);
    chk("t2_code0", 32'(frm_code[0][0]), 32'h000);
    chk("t2_code1", 32'(frm_code[0][1]), 32'h3FF);
    chk("t2_code2", 32'(frm_code[0][2]), 32'h155);
    chk("t2_code3", 32'(frm_code[0][3]), 32'h2AA);
    for (int j = 1; j < 4; j++)
      chk("t2_spacing", 32'(cnv_cyc[0][j] - cnv_cyc[0][j-1]), 32'd64);
    chk("t2_overrun", 32'(if0.overrun_cnt), 32'd0);
    chk("t2_cnvst_count", 32'(cnv_n[0]), 32'd4);

    // missing eoc
    do_reset();
    sar_on[0] = 1'b0;
    drv_en[0] = 1'b1;
    wait_cnv(0, 1, 10);
    c0 = cnv_cyc[0][0];
    k = 0;
    while (cyc < c0 + 255 && k < 400) begin tick(); k++; end
    chk("t3_flag_before", 32'(if0.timeout_flag), 32'd0);
    chk("t3_busy_last", 32'(if0.busy), 32'd1);
    tick();
    chk("t3_flag_set", 32'(if0.timeout_flag), 32'd1);
    chk("t3_busy_drop", 32'(if0.busy), 32'd0);
    wait_cnv(0, 2, 10);
    drv_en[0] = 1'b0;
    chk("t3_next_cnvst", 32'(cnv_cyc[0][1] - c0), 32'd257);
    chk("t3_no_capture", 32'(if0.last_code), 32'd0);
    chk("t3_no_frame", 32'(frm_n[0]), 32'd0);
    do_reset();
    sar_on[0] = 1'b1;
    chk("t3_flag_cleared", 32'(if0.timeout_flag), 32'd0);

    // reset during bit 5 of a frame
    codes[0][0] = 10'h2A5; lats[0][0] = 12;
    drv_en[0] = 1'b1;
    wait_cnv(0, 1, 10);
    k = 0;
    while (if0.cs_n && k < 100) begin tick(); k++; end
    f0 = cyc;
    while (cyc < f0 + 23 && k < 200) begin tick(); k++; end
    chk("t4_mid_cs_n", 32'(if0.cs_n), 32'd0);
    chk("t4_mid_sclk", 32'(if0.sclk_out), 32'd1);
    rst = 1'b1;
    drv_en[0] = 1'b0;
    tick();
    chk("t4_cs_n", 32'(if0.cs_n), 32'd1);
    chk("t4_sclk", 32'(if0.sclk_out), 32'd0);
    chk("t4_overrun", 32'(if0.overrun_cnt), 32'd0);
    chk("t4_last_code", 32'(if0.last_code), 32'd0);
    rst = 1'b0;
    repeat (30) tick();
    chk("t4_no_cnvst", 32'(cnv_n[0]), 32'd1);
    drv_en[0] = 1'b1;
    tick();
    chk("t4_cnvst_resume", 32'(if0.cnvst), 32'd1);
    drv_en[0] = 1'b0;
    repeat (150) tick();

    // overrun: fast rate, slow serial clock
    do_reset();
    codes[1][0] = 10'h011; codes[1][1] = 10'h022; codes[1][2] = 10'h033;
    codes[1][3] = 10'h044; codes[1][4] = 10'h055;
    for (int j = 0; j < 5; j++) lats[1][j] = 5;
    drv_en[1] = 1'b1;
    wait_cnv(1, 4, 200);
    chk("t5_overrun_mid", 32'(if1.overrun_cnt), 32'd1);
    wait_cnv(1, 5, 50);
    drv_en[1] = 1'b0;
    wait_frm(1, 2, 400);
    repeat (40) tick();
    chk("t5_spacing", 32'(cnv_cyc[1][1] - cnv_cyc[1][0]), 32'd20);
    chk("t5_frames", 32'(frm_n[1]), 32'd2);
    chk("t5_code0", 32'(frm_code[1][0]), 32'h011);
    chk("t5_code1_newest", 32'(frm_code[1][1]), 32'h055);
    chk("t5_frame_len", 32'(frm_len[1][0]), 32'd81);
    chk("t5_overrun", 32'(if1.overrun_cnt), 32'd3);
    chk("t5_last_code", 32'(if1.last_code), 32'h055);

    // capture in the same cycle as the serializer hand-off
    do_reset();
    codes[1][0] = 10'h1C3; codes[1][1] = 10'h0F0; codes[1][2] = 10'h30C;
    lats[1][0] = 5; lats[1][1] = 5; lats[1][2] = 56;
    drv_en[1] = 1'b1;
    wait_cnv(1, 3, 100);
    drv_en[1] = 1'b0;
    wait_frm(1, 3, 600);
    repeat (20) tick();
    c0 = cnv_cyc[1][0];
    chk("t6_eoc_cycle", 32'(eoc_cyc[1] - c0), 32'd96);
    chk("t6_frame1_start", 32'(frm_start[1][1] - c0), 32'd97);
    chk("t6_frames", 32'(frm_n[1]), 32'd3);
    chk("t6_code0", 32'(frm_code[1][0]), 32'h1C3);
    chk("t6_code1", 32'(frm_code[1][1]), 32'h0F0);
    chk("t6_code2", 32'(frm_code[1][2]), 32'h30C);
    chk("t6_overrun", 32'(if1.overrun_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
